// File: rtl/gpu_mmio_cmd_regs.sv
// MMIO register block between the SPI bridge and the GPU core.
// It holds the control/status registers and the command FIFO that feeds the core.
module gpu_mmio_cmd_regs #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] VERSION    = 32'h0001_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_bus_we,
  input  logic [ADDR_WIDTH-1:0] i_bus_addr,
  input  logic [DATA_WIDTH-1:0] i_bus_wdata,
  output logic [DATA_WIDTH-1:0] o_bus_rdata,
  output logic                  o_cmd_valid,
  input  logic                  i_cmd_ready,
  output logic [DATA_WIDTH-1:0] o_cmd_data,
  input  logic                  i_done_pulse,
  output logic                  o_irq
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [5:0] AddrCtrl    = 6'h00;
  localparam logic [5:0] AddrStatus  = 6'h01;
  localparam logic [5:0] AddrPush    = 6'h02;
  localparam logic [5:0] AddrScratch = 6'h03;
  localparam logic [5:0] AddrVersion = 6'h04;
  localparam logic [5:0] AddrDone    = 6'h05;
  localparam logic [5:0] AddrThresh  = 6'h06;

  logic [5:0] word_addr;
  logic       unused_addr;
  assign word_addr   = i_bus_addr[7:2];
  assign unused_addr = ^{i_bus_addr[ADDR_WIDTH-1:8], i_bus_addr[1:0]};

  logic                  ctrl_en_q, ctrl_irq_en_q;
  logic [DATA_WIDTH-1:0] scratch_q;
  logic [31:0]           thresh_q, done_cnt_q;
  logic                  ovf_q, dpend_q, irq_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;

  logic        ctrl_wr, status_wr, flush, empty, full, pop;
  logic        push_req, push, ovf_set, dpend_set;
  logic [31:0] done_next;

  always_comb begin
    ctrl_wr   = i_bus_we && (word_addr == AddrCtrl);
    status_wr = i_bus_we && (word_addr == AddrStatus);
    push_req  = i_bus_we && (word_addr == AddrPush);
    flush     = ctrl_wr && i_bus_wdata[1];
    empty     = (count_q == '0);
    full      = (count_q == CntW'(FIFO_DEPTH));
    // Flush beats a same-cycle pop; a pop frees the slot a full-FIFO push needs.
    pop       = ctrl_en_q && !empty && i_cmd_ready && !flush;
    push      = push_req && (!full || pop);
    ovf_set   = push_req && full && !pop;
    done_next = done_cnt_q + 32'd1;
    dpend_set = i_done_pulse && (done_next >= thresh_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_en_q     <= 1'b0;
      ctrl_irq_en_q <= 1'b0;
      scratch_q     <= '0;
      thresh_q      <= 32'd1;
      done_cnt_q    <= '0;
      ovf_q         <= 1'b0;
      dpend_q       <= 1'b0;
      irq_q         <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      if (ctrl_wr) begin
        ctrl_en_q     <= i_bus_wdata[0];
        ctrl_irq_en_q <= i_bus_wdata[2];
      end
      if (i_bus_we && (word_addr == AddrScratch)) scratch_q <= i_bus_wdata;
      if (i_bus_we && (word_addr == AddrThresh))  thresh_q  <= 32'(i_bus_wdata);
      if (i_done_pulse) done_cnt_q <= done_next;

      if (ovf_set) ovf_q <= 1'b1;
      else if (status_wr && i_bus_wdata[10]) ovf_q <= 1'b0;
      // A new completion outranks a software clear in the same cycle.
      if (dpend_set) dpend_q <= 1'b1;
      else if (status_wr && i_bus_wdata[11]) dpend_q <= 1'b0;

      irq_q <= ctrl_irq_en_q && (dpend_q || ovf_q);

      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        if (push && !pop)      count_q <= count_q + CntW'(1);
        else if (pop && !push) count_q <= count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= i_bus_wdata;
  end

  assign o_cmd_valid = !rst && ctrl_en_q && !empty;
  assign o_cmd_data  = mem_q[rd_ptr_q];
  assign o_irq       = !rst && irq_q;

  // While rst is high the bus sees the reset image, not the not-yet-cleared flops.
  always_comb begin
    o_bus_rdata = '0;
    case (word_addr)
      AddrCtrl: begin
        if (!rst) o_bus_rdata[2:0] = {ctrl_irq_en_q, 1'b0, ctrl_en_q};
      end
      AddrStatus: begin
        if (rst) begin
          o_bus_rdata[8] = 1'b1;
        end else begin
          o_bus_rdata[7:0] = 8'(count_q);
          o_bus_rdata[8]   = empty;
          o_bus_rdata[9]   = full;
          o_bus_rdata[10]  = ovf_q;
          o_bus_rdata[11]  = dpend_q;
        end
      end
      AddrScratch: begin
        if (!rst) o_bus_rdata = scratch_q;
      end
      AddrVersion: o_bus_rdata = DATA_WIDTH'(VERSION);
      AddrDone: begin
        if (!rst) o_bus_rdata = DATA_WIDTH'(done_cnt_q);
      end
      AddrThresh: o_bus_rdata = rst ? DATA_WIDTH'(1) : DATA_WIDTH'(thresh_q);
      default: o_bus_rdata = '0;
    endcase
  end

endmodule

// File: doc/gpu_mmio_cmd_regs.md
GPU_MMIO_CMD_REGS -- requirements
Module: gpu_mmio_cmd_regs

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, bus address width.
REQ-002 Parameter DATA_WIDTH, default 32, bus and command word width.
REQ-003 Parameter FIFO_DEPTH, default 8, command FIFO entries; power of two, 2 to 128.
REQ-004 Parameter VERSION, default 32'h0001_0000, value returned by the VERSION register.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 i_bus_we  input  1  one-cycle write strobe from the SPI bridge.
REQ-008 i_bus_addr  input  ADDR_WIDTH  byte address of the access.
REQ-009 i_bus_wdata  input  DATA_WIDTH  write data.
REQ-010 o_bus_rdata  output  DATA_WIDTH  read data, combinational from i_bus_addr.
REQ-011 o_cmd_valid  output  1  command word available to the GPU core.
REQ-012 i_cmd_ready  input  1  core accepts the word; pop occurs when valid and ready are both high.
REQ-013 o_cmd_data  output  DATA_WIDTH  head-of-FIFO command word.
REQ-014 i_done_pulse  input  1  one-cycle pulse from the core per completed command.
REQ-015 o_irq  output  1  level interrupt.

Function
REQ-016 Decode i_bus_addr[7:2]; bits above 7 ignored; bits [1:0] ignored.
REQ-017 Map: 0x00 CTRL RW; 0x04 STATUS RO/W1C; 0x08 CMD_PUSH WO; 0x0C SCRATCH RW; 0x10 VERSION RO; 0x14 DONE_COUNT RO; 0x18 IRQ_THRESH RW.
REQ-018 Unmapped addresses read 0; writes to them, to VERSION and to DONE_COUNT are ignored.
REQ-019 CMD_PUSH reads 0.
REQ-020 CTRL bit0 ENABLE, bit1 FLUSH, bit2 IRQ_EN; other bits read 0.
REQ-021 FLUSH is self-clearing and always reads 0.
REQ-022 Register writes take effect on the clock edge of the i_bus_we cycle; reads in the following cycle return the new value.
REQ-023 STATUS bits: [7:0] count, [8] empty, [9] full, [10] OVERFLOW sticky, [11] DONE_PENDING sticky; other bits read 0.
REQ-024 Writing 1 to STATUS bit10 or bit11 clears that bit; writing 0 leaves it unchanged.
REQ-025 Write to CMD_PUSH when not full enqueues i_bus_wdata; the word is visible on o_cmd_data/o_cmd_valid the next cycle.
REQ-026 Write to CMD_PUSH when full and no pop that cycle drops the data and sets OVERFLOW.
REQ-027 Write to CMD_PUSH when full with a pop in the same cycle is accepted; count is unchanged.
REQ-028 Push and pop in the same cycle on a non-empty FIFO leave count unchanged.
REQ-029 o_cmd_valid = ENABLE and not empty.
REQ-030 While ENABLE=0, pushes are still accepted and no pops occur.
REQ-031 FIFO order is strict FIFO; read and write pointers wrap modulo FIFO_DEPTH.
REQ-032 Count saturates at FIFO_DEPTH by construction and is never exceeded.
REQ-033 A CTRL write with FLUSH=1 empties the FIFO on that edge; OVERFLOW is unaffected.
REQ-034 Flush wins over a same-cycle pop.
REQ-035 The other CTRL bits from the same write still load.
REQ-036 i_done_pulse increments 32-bit DONE_COUNT, wrapping 0xFFFF_FFFF to 0.
REQ-037 Each i_done_pulse sets DONE_PENDING if DONE_COUNT+1 >= IRQ_THRESH (unsigned).
REQ-038 A same-cycle DONE_PENDING set and W1C clear leaves DONE_PENDING set.
REQ-039 o_irq is registered: IRQ_EN and (DONE_PENDING or OVERFLOW), one cycle after the source bit changes.

Reset
REQ-040 While rst=1: CTRL=0, SCRATCH=0, IRQ_THRESH=1, DONE_COUNT=0, OVERFLOW=0, DONE_PENDING=0, FIFO pointers and count=0.
REQ-041 While rst=1: o_cmd_valid=0, o_irq=0.
REQ-042 o_bus_rdata reflects the reset register values while rst=1.
REQ-043 Reset mid-operation discards FIFO contents; bus writes during rst=1 are ignored.

Verification
REQ-044 Reset, read 0x10 -> 0x0001_0000; read 0x04 -> 0x0000_0100 (empty).
REQ-045 CTRL=1, push 0xA1, 0xB2, 0xC3, ready held high -> o_cmd_data sequence A1, B2, C3 on consecutive valid cycles, then empty.
REQ-046 CTRL=0, push 9 words with FIFO_DEPTH=8 -> STATUS=0x0000_0608; write 0x400 to STATUS -> 0x0000_0208.
REQ-047 Full FIFO, ENABLE=1, ready=1, simultaneous push -> count stays 8, OVERFLOW stays 0, new word emerges last.
REQ-048 Write CTRL=0x5 with IRQ_THRESH=3, three i_done_pulse -> DONE_COUNT=3, o_irq rises one cycle after the third pulse, W1C bit11 drops o_irq.
REQ-049 Assert rst with 4 queued entries -> the next cycle has o_cmd_valid=0, STATUS count 0, SCRATCH 0.
